fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: decides each cycle whether the fetch unit increments its
// PC or reloads it from pcVal. It implements run, single-step and halt
// control, and counts retired instructions.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   start             - pulse, begin or resume free-running fetch
//   haltReq           - level, stop PC advance (also blocks start)
//   stepReq           - pulse, advance one instruction while stopped
//   branchReq         - redirect the PC this cycle (RUN/STEP only)
//   branchTarget      - redirect address, valid with branchReq
//   instruction       - current instruction from the fetch unit
//   pcVal, pcOverride - combinational PC load value / load enable to fetch unit
//   pcShadow          - registered mirror of the fetch unit PC
//   instrValid        - current instruction retires this cycle
//   state             - IDLE=0, RUN=1, STEP=2, HALTED=3
//   retiredCount      - saturating count of retired instructions
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        haltReq,
    input  logic        stepReq,
    input  logic        branchReq,
    input  logic [7:0]  branchTarget,
    input  logic [7:0]  instruction,
    output logic [7:0]  pcVal,
    output logic        pcOverride,
    output logic [7:0]  pcShadow,
    output logic        instrValid,
    output logic [1:0]  state,
    output logic [15:0] retiredCount
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state_q;
    state_t state_next;
    logic   active;

    // An instruction retires in every RUN or STEP cycle.
    assign active = (state_q == RUN) || (state_q == STEP);
    assign state  = state_q;

    // Next-state decode; start is ignored while haltReq is high.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start && !haltReq) begin
                    state_next = RUN;
                end else if (stepReq) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (haltReq || (instruction == HALT_OPCODE)) begin
                    state_next = HALTED;
                end
            end
            STEP: state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    // Fetch-unit PC control: reset and stopped states force a reload,
    // a branch in an active state redirects, otherwise the unit increments.
    always_comb begin
        pcOverride = 1'b1;
        pcVal      = pcShadow;
        if (reset) begin
            pcVal = RESET_PC;
        end else if (active) begin
            if (branchReq) begin
                pcVal = branchTarget;
            end else begin
                pcOverride = 1'b0;
                pcVal      = pcShadow + 8'd1;
            end
        end
    end

    // State, PC mirror, retire flag and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pcShadow     <= RESET_PC;
            retiredCount <= '0;
            instrValid   <= 1'b0;
        end else begin
            state_q    <= state_next;
            instrValid <= (state_next == RUN) || (state_next == STEP);
            if (active) begin
                // 8-bit add wraps FF -> 00 by construction
                pcShadow <= branchReq ? branchTarget : pcShadow + 8'd1;
                if (retiredCount != CNT_MAX) begin
                    retiredCount <= retiredCount + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus randomized stimulus,
// compared each cycle against a behavioural model of run/step/halt.
module tb_fetch_sequencer;

    localparam logic [7:0] RESET_PC = 8'h00;
    localparam logic [7:0] HALT_OP  = 8'hFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        haltReq = 1'b0;
    logic        stepReq = 1'b0;
    logic        branchReq = 1'b0;
    logic [7:0]  branchTarget = 8'h00;
    logic [7:0]  instruction = 8'h00;
    logic [7:0]  pcVal;
    logic        pcOverride;
    logic [7:0]  pcShadow;
    logic        instrValid;
    logic [1:0]  state;
    logic [15:0] retiredCount;

    fetch_sequencer #(.RESET_PC(RESET_PC), .HALT_OPCODE(HALT_OP)) dut (
        .clk(clk), .reset(reset), .start(start), .haltReq(haltReq),
        .stepReq(stepReq), .branchReq(branchReq), .branchTarget(branchTarget),
        .instruction(instruction), .pcVal(pcVal), .pcOverride(pcOverride),
        .pcShadow(pcShadow), .instrValid(instrValid), .state(state),
        .retiredCount(retiredCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit quiet = 1'b0;

    // Reference model: mode 0 idle, 1 running, 2 single step, 3 halted.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_active();
        return (m_mode == 1) || (m_mode == 2);
    endfunction

    // One clock cycle: apply inputs, compare outputs, then advance the model.
    task automatic cycle(input bit r, input bit s, input bit h, input bit st,
                         input bit b, input logic [7:0] t, input logic [7:0] ins);
        bit act;
        @(negedge clk);
        reset = r; start = s; haltReq = h; stepReq = st;
        branchReq = b; branchTarget = t; instruction = ins;
        #1;
        act = m_active();
        if (!quiet) begin
            check("state", 32'(state), 32'(m_mode));
            check("pcShadow", 32'(pcShadow), 32'(m_pc));
            check("instrValid", 32'(instrValid), 32'(act));
            check("retiredCount", 32'(retiredCount), 32'(m_cnt));
            if (r) begin
                check("rst_override", 32'(pcOverride), 32'd1);
                check("rst_pcVal", 32'(pcVal), 32'(RESET_PC));
            end else if (!act) begin
                check("hold_override", 32'(pcOverride), 32'd1);
                check("hold_pcVal", 32'(pcVal), 32'(m_pc));
            end else if (b) begin
                check("br_override", 32'(pcOverride), 32'd1);
                check("br_pcVal", 32'(pcVal), 32'(t));
            end else begin
                check("run_override", 32'(pcOverride), 32'd0);
            end
        end
        @(posedge clk);
        if (r) begin
            m_mode = 0;
            m_pc   = int'(RESET_PC);
            m_cnt  = 0;
        end else begin
            if (act) begin
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_pc  = b ? int'(t) : (m_pc + 1) % 256;
            end
            case (m_mode)
                0, 3: begin
                    if (s && !h) m_mode = 1;
                    else if (st) m_mode = 2;
                end
                1: if (h || ins == HALT_OP) m_mode = 3;
                default: m_mode = 3;
            endcase
        end
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        // Reset and first run of five instructions.
        cycle(1, 0, 0, 0, 0, 8'h00, 8'h00);
        cycle(1, 0, 0, 0, 0, 8'h00, 8'h00);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", 32'(pcShadow), 32'(RESET_PC));
        check("rst_cnt", 32'(retiredCount), 32'd0);
        check("rst_iv", 32'(instrValid), 32'd0);
        idle_cycle();
        idle_cycle();
        #1;
        check("no_progress_pc", 32'(pcShadow), 32'(RESET_PC));
        cycle(0, 1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) idle_cycle();
        #1;
        check("run5_pc", 32'(pcShadow), 32'h05);
        check("run5_cnt", 32'(retiredCount), 32'd5);

        // Branch to FE from 10, then wrap through FF to 00.
        for (int i = 0; i < 11; i++) idle_cycle();
        #1;
        check("at_10", 32'(pcShadow), 32'h10);
        cycle(0, 0, 0, 0, 1, 8'hFE, 8'h00);
        #1;
        check("br_FE", 32'(pcShadow), 32'hFE);
        idle_cycle();
        idle_cycle();
        #1;
        check("wrap_00", 32'(pcShadow), 32'h00);

        // Halting opcode at 07.
        cycle(0, 0, 0, 0, 1, 8'h07, 8'h00);
        cycle(0, 0, 0, 0, 0, 8'h00, HALT_OP);
        #1;
        check("halt_state", 32'(state), 32'd3);
        check("halt_pc", 32'(pcShadow), 32'h08);
        check("halt_cnt", 32'(retiredCount), 32'd21);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 8'h55, 8'h00);
        #1;
        check("halted_cnt", 32'(retiredCount), 32'd21);
        check("halted_pcVal", 32'(pcVal), 32'h08);

        // Single step, then start blocked by haltReq.
        cycle(0, 0, 0, 1, 0, 8'h00, 8'h00);
        #1;
        check("step_state", 32'(state), 32'd2);
        idle_cycle();
        #1;
        check("step_done_state", 32'(state), 32'd3);
        check("step_done_pc", 32'(pcShadow), 32'h09);
        cycle(0, 1, 1, 0, 0, 8'h00, 8'h00);
        #1;
        check("start_blocked", 32'(state), 32'd3);

        // Reset during RUN at 33, then resume from RESET_PC.
        cycle(0, 1, 0, 0, 0, 8'h00, 8'h00);
        cycle(0, 0, 0, 0, 1, 8'h33, 8'h00);
        #1;
        check("at_33", 32'(pcShadow), 32'h33);
        cycle(1, 0, 0, 0, 1, 8'h77, 8'h00);
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_pc", 32'(pcShadow), 32'(RESET_PC));
        check("mid_rst_cnt", 32'(retiredCount), 32'd0);
        cycle(0, 1, 0, 0, 0, 8'h00, 8'h00);
        idle_cycle();
        #1;
        check("resume_pc", 32'(pcShadow), 32'(RESET_PC) + 32'd1);

        // Randomized stimulus against the model.
        for (int i = 0; i < 2000; i++) begin
            bit r, s, h, st, b;
            logic [7:0] t, ins;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 12);
            h   = ($urandom_range(0, 99) < 15);
            st  = ($urandom_range(0, 99) < 12);
            b   = ($urandom_range(0, 99) < 15);
            t   = 8'($urandom_range(0, 255));
            ins = ($urandom_range(0, 99) < 10) ? HALT_OP : 8'($urandom_range(0, 254));
            cycle(r, s, h, st, b, t, ins);
        end

        // Long run to reach counter saturation.
        cycle(1, 0, 0, 0, 0, 8'h00, 8'h00);
        cycle(0, 1, 0, 0, 0, 8'h00, 8'h00);
        quiet = 1'b1;
        for (int i = 0; i < 65540; i++) idle_cycle();
        quiet = 1'b0;
        #1;
        check("sat_cnt", 32'(retiredCount), 32'h0000FFFF);
        idle_cycle();
        idle_cycle();
        #1;
        check("sat_hold", 32'(retiredCount), 32'h0000FFFF);
        check("sat_state", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
